// File: rtl/openhw_elastic_pipe_pkg.sv
// Shared definitions for the elastic pipeline: occupancy sizing and the
// per-cycle occupancy update classification.
package openhw_elastic_pipe_pkg;

  typedef enum logic [1:0] {
    OCC_HOLD = 2'd0,
    OCC_INC  = 2'd1,
    OCC_DEC  = 2'd2,
    OCC_CLR  = 2'd3
  } occ_op_e;

  // Counter width able to represent 0..stages inclusive.
  function automatic int unsigned cnt_width(input int unsigned stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/openhw_elastic_pipe_if.sv
// Valid/ready payload channel used on both sides of the elastic pipe.
// A transfer happens on a posedge where valid & ready are both high; while
// valid & ~ready the master holds valid and data stable.
interface openhw_elastic_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/openhw_elastic_pipe_stage.sv
// One elastic stage: a valid bit plus a data register that is only written
// when valid data is loaded, so empty-slot traffic never toggles the payload.
module openhw_pipe_stage #(
  parameter int unsigned         WIDTH     = 8,
  parameter logic [WIDTH-1:0]    RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             en,
  input  logic             ld,
  input  logic             v_in,
  input  logic [WIDTH-1:0] d_in,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v <= 1'b0;
      d <= RESET_VAL;
    end else begin
      if (flush) begin
        v <= 1'b0;
      end else if (en) begin
        v <= v_in;
      end
      // Flush leaves the payload untouched; only the valid bit is cleared.
      if (ld && !flush) begin
        d <= d_in;
      end
    end
  end

endmodule

// File: rtl/openhw_elastic_pipe.sv
// Elastic pipeline of STAGES valid/data registers with a combinational ready
// chain, bubble collapse, synchronous flush and a registered occupancy count.
module openhw_elastic_pipe
  import openhw_elastic_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  openhw_elastic_pipe_if.slave             in_if,
  openhw_elastic_pipe_if.master            out_if,
  output logic [cnt_width(STAGES)-1:0]     occupancy
);

  localparam int unsigned CNTW = cnt_width(STAGES);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] v_up;
  logic [STAGES:0]   rdy;
  logic [WIDTH-1:0]  d    [STAGES];
  logic [WIDTH-1:0]  d_up [STAGES];
  logic              accept;
  logic              deliver;
  occ_op_e           occ_op;

  // A stage loads when it is empty or its contents move on this cycle.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_if.ready;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      rdy[i] = ~v[i] | rdy[i+1];
    end
  end

  for (genvar i = 0; i < int'(STAGES); i++) begin : g_stage
    if (i == 0) begin : g_head
      assign v_up[i] = in_if.valid;
      assign d_up[i] = in_if.data;
    end else begin : g_body
      assign v_up[i] = v[i-1];
      assign d_up[i] = d[i-1];
    end

    openhw_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .en    (rdy[i]),
      .ld    (rdy[i] & v_up[i]),
      .v_in  (v_up[i]),
      .d_in  (d_up[i]),
      .v     (v[i]),
      .d     (d[i])
    );
  end

  assign in_if.ready  = rdy[0] & ~flush;
  assign out_if.valid = v[STAGES-1] & ~flush;
  assign out_if.data  = d[STAGES-1];

  assign accept  = in_if.valid & in_if.ready;
  assign deliver = out_if.valid & out_if.ready;

  always_comb begin
    occ_op = OCC_HOLD;
    if (flush) begin
      occ_op = OCC_CLR;
    end else if (accept && !deliver) begin
      occ_op = OCC_INC;
    end else if (deliver && !accept) begin
      occ_op = OCC_DEC;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occupancy <= '0;
    end else begin
      case (occ_op)
        OCC_CLR:  occupancy <= '0;
        OCC_INC:  occupancy <= occupancy + CNTW'(1);
        OCC_DEC:  occupancy <= occupancy - CNTW'(1);
        default:  occupancy <= occupancy;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_occ_popcount : assert property (@(posedge clk) disable iff (reset)
    occupancy == CNTW'($countones(v)));

  a_stall_stable : assert property (@(posedge clk) disable iff (reset)
    (out_if.valid && !out_if.ready) |=> $stable(out_if.data));
`endif

endmodule

// File: tb/tb_openhw_elastic_pipe.sv
// Bench for openhw_elastic_pipe: four configurations side by side, directed
// scenarios with literal expectations, then randomized valid/ready traffic.
module tb_openhw_elastic_pipe;

  localparam int NDUT = 4;

  function automatic int st_of(input int k);
    case (k)
      0:       return 2;
      1:       return 3;
      2:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic int wd_of(input int k);
    case (k)
      0, 1:    return 8;
      2:       return 1;
      default: return 64;
    endcase
  endfunction

  function automatic logic [63:0] rv_of(input int k);
    case (k)
      0:       return 64'h5C;
      1:       return 64'h00;
      2:       return 64'h1;
      default: return 64'hDEAD_BEEF_0123_4567;
    endcase
  endfunction

  function automatic logic [63:0] mask_of(input int k);
    if (wd_of(k) >= 64) return '1;
    return (64'd1 << wd_of(k)) - 64'd1;
  endfunction

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        flush_a     [NDUT];
  logic        in_valid_a  [NDUT];
  logic [63:0] in_data_a   [NDUT];
  logic        out_ready_a [NDUT];
  logic        in_ready_a  [NDUT];
  logic        out_valid_a [NDUT];
  logic [63:0] out_data_a  [NDUT];
  logic [7:0]  occ_a       [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int          W    = wd_of(g);
    localparam int          S    = st_of(g);
    localparam logic [63:0] RV64 = rv_of(g);
    localparam int          CW   = $clog2(S + 1);

    logic [CW-1:0] occ;
    openhw_elastic_pipe_if #(.WIDTH(W)) in_if ();
    openhw_elastic_pipe_if #(.WIDTH(W)) out_if ();

    assign in_if.valid    = in_valid_a[g];
    assign in_if.data     = in_data_a[g][W-1:0];
    assign out_if.ready   = out_ready_a[g];
    assign in_ready_a[g]  = in_if.ready;
    assign out_valid_a[g] = out_if.valid;
    assign out_data_a[g]  = 64'(out_if.data);
    assign occ_a[g]       = 8'(occ);

    openhw_elastic_pipe #(
      .WIDTH     (W),
      .STAGES    (S),
      .RESET_VAL (RV64[W-1:0])
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush_a[g]),
      .in_if     (in_if),
      .out_if    (out_if),
      .occupancy (occ)
    );
  end

  // behavioural model: FIFO list of items, each with its current stage index
  int          m_cnt [NDUT];
  logic [63:0] m_dat [NDUT][4];
  int          m_pos [NDUT][4];
  bit          m_mv  [NDUT][4];
  bit          p_ov  [NDUT];
  bit          p_ir  [NDUT];
  bit          pending [NDUT];
  int          rate_in [NDUT];
  int          rate_out [NDUT];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // scoreboard compare: outputs against the model, every cycle, every DUT
  task automatic settle();
    #1;
    for (int k = 0; k < NDUT; k++) begin
      int s;
      int last;
      s = st_of(k);
      if (reset) m_cnt[k] = 0;
      p_ov[k] = !flush_a[k] && m_cnt[k] > 0 && m_pos[k][0] == s - 1;
      for (int j = 0; j < m_cnt[k]; j++) begin
        if (j == 0)
          m_mv[k][j] = (m_pos[k][0] == s - 1) ? out_ready_a[k] : 1'b1;
        else
          m_mv[k][j] = (m_pos[k][j-1] == m_pos[k][j] + 1) ? m_mv[k][j-1] : 1'b1;
      end
      last = m_cnt[k] - 1;
      p_ir[k] = !flush_a[k] &&
                (m_cnt[k] == 0 || m_pos[k][last] != 0 || m_mv[k][last]);
      chk($sformatf("d%0d_out_valid", k), 64'(out_valid_a[k]), 64'(p_ov[k]));
      chk($sformatf("d%0d_in_ready", k), 64'(in_ready_a[k]), 64'(p_ir[k]));
      chk($sformatf("d%0d_occupancy", k), 64'(occ_a[k]), 64'(m_cnt[k]));
      if (p_ov[k]) chk($sformatf("d%0d_out_data", k), out_data_a[k], m_dat[k][0]);
      if (reset) chk($sformatf("d%0d_reset_data", k), out_data_a[k], rv_of(k));
    end
  endtask

  task automatic advance();
    for (int k = 0; k < NDUT; k++) begin
      bit acc;
      bit dlv;
      int n;
      acc = in_valid_a[k] && p_ir[k];
      dlv = p_ov[k] && out_ready_a[k];
      n   = 0;
      if (reset) begin
        m_cnt[k]   = 0;
        pending[k] = 1'b0;
      end else if (flush_a[k]) begin
        m_cnt[k]   = 0;
        pending[k] = in_valid_a[k];
      end else begin
        for (int j = 0; j < m_cnt[k]; j++) begin
          if (!(j == 0 && dlv)) begin
            m_dat[k][n] = m_dat[k][j];
            m_pos[k][n] = m_pos[k][j] + (m_mv[k][j] ? 1 : 0);
            n++;
          end
        end
        if (acc && n < 4) begin
          m_dat[k][n] = in_data_a[k] & mask_of(k);
          m_pos[k][n] = 0;
          n++;
        end
        m_cnt[k]   = n;
        pending[k] = in_valid_a[k] && !acc;
      end
    end
    @(negedge clk);
  endtask

  // driver tasks
  task automatic drive(input int k, input bit v, input logic [63:0] d, input bit ordy, input bit fl);
    in_valid_a[k]  = v;
    in_data_a[k]   = d;
    out_ready_a[k] = ordy;
    flush_a[k]     = fl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 1'b0, 64'h0, 1'b1, 1'b0);
      drive(1, 1'b0, 64'h0, 1'b1, 1'b0);
      settle();
      advance();
    end
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      drive(k, 1'b0, 64'h0, 1'b1, 1'b0);
      m_cnt[k]   = 0;
      pending[k] = 1'b0;
    end
    @(negedge clk);
    settle();
    chk("rst_out_data", out_data_a[0], 64'h5C);
    chk("rst_occ", 64'(occ_a[0]), 64'd0);
    advance();

    // reset mid-stream with two items in flight
    reset = 1'b0;
    drive(0, 1'b1, 64'h31, 1'b0, 1'b0); settle(); chk("t1_ir_a", 64'(in_ready_a[0]), 64'd1); advance();
    drive(0, 1'b1, 64'h32, 1'b0, 1'b0); settle(); advance();
    drive(0, 1'b0, 64'h00, 1'b0, 1'b0); reset = 1'b1; settle();
    chk("t1_rst_ov", 64'(out_valid_a[0]), 64'd0);
    chk("t1_rst_od", out_data_a[0], 64'h5C);
    chk("t1_rst_occ", 64'(occ_a[0]), 64'd0);
    advance();
    reset = 1'b0;
    drive(0, 1'b1, 64'hA5, 1'b1, 1'b0); settle(); chk("t1_a5_ir", 64'(in_ready_a[0]), 64'd1); advance();
    drive(0, 1'b0, 64'h00, 1'b1, 1'b0); settle(); chk("t1_a5_early", 64'(out_valid_a[0]), 64'd0); advance();
    settle();
    chk("t1_a5_ov", 64'(out_valid_a[0]), 64'd1);
    chk("t1_a5_od", out_data_a[0], 64'hA5);
    advance();
    idle(2);

    // back-to-back streaming
    for (int n = 0; n < 18; n++) begin
      drive(0, n < 16, 64'(n + 1), 1'b1, 1'b0);
      settle();
      if (n < 16) chk("t2_ir", 64'(in_ready_a[0]), 64'd1);
      if (n >= 2) begin
        chk("t2_ov", 64'(out_valid_a[0]), 64'd1);
        chk("t2_od", out_data_a[0], 64'(n - 1));
      end
      if (n >= 2 && n <= 16) chk("t2_occ", 64'(occ_a[0]), 64'd2);
      advance();
    end
    idle(2);

    // backpressure
    drive(0, 1'b1, 64'h11, 1'b0, 1'b0); settle(); chk("t3_ir11", 64'(in_ready_a[0]), 64'd1); advance();
    drive(0, 1'b1, 64'h22, 1'b0, 1'b0); settle(); chk("t3_ir22", 64'(in_ready_a[0]), 64'd1); advance();
    drive(0, 1'b1, 64'h33, 1'b0, 1'b0); settle();
    chk("t3_ir33", 64'(in_ready_a[0]), 64'd0);
    chk("t3_full", 64'(occ_a[0]), 64'd2);
    chk("t3_od11", out_data_a[0], 64'h11);
    advance();
    drive(0, 1'b1, 64'h33, 1'b1, 1'b0); settle();
    chk("t3_ir_pass", 64'(in_ready_a[0]), 64'd1);
    chk("t3_dlv11", out_data_a[0], 64'h11);
    advance();
    drive(0, 1'b0, 64'h00, 1'b1, 1'b0); settle(); chk("t3_od22", out_data_a[0], 64'h22); advance();
    settle(); chk("t3_od33", out_data_a[0], 64'h33); chk("t3_occ1", 64'(occ_a[0]), 64'd1); advance();
    settle(); chk("t3_empty", 64'(occ_a[0]), 64'd0); advance();

    // bubble collapse on the three-stage pipe
    drive(1, 1'b1, 64'h41, 1'b0, 1'b0); settle(); advance();
    drive(1, 1'b0, 64'h00, 1'b0, 1'b0); settle(); advance();
    settle(); advance();
    drive(1, 1'b1, 64'h42, 1'b0, 1'b0); settle();
    chk("t4_od41", out_data_a[1], 64'h41);
    chk("t4_ir42", 64'(in_ready_a[1]), 64'd1);
    advance();
    drive(1, 1'b1, 64'h43, 1'b0, 1'b0); settle(); chk("t4_ir43", 64'(in_ready_a[1]), 64'd1); advance();
    drive(1, 1'b1, 64'h44, 1'b0, 1'b0); settle();
    chk("t4_occ3", 64'(occ_a[1]), 64'd3);
    chk("t4_ir44", 64'(in_ready_a[1]), 64'd0);
    advance();
    drive(1, 1'b1, 64'h44, 1'b1, 1'b0); settle(); chk("t4_ir_pass", 64'(in_ready_a[1]), 64'd1); advance();
    idle(5);

    // flush with a full pipe and a held input
    drive(0, 1'b1, 64'h51, 1'b0, 1'b0); settle(); advance();
    drive(0, 1'b1, 64'h52, 1'b0, 1'b0); settle(); advance();
    drive(0, 1'b1, 64'h53, 1'b0, 1'b1); settle();
    chk("t5_fl_ir", 64'(in_ready_a[0]), 64'd0);
    chk("t5_fl_ov", 64'(out_valid_a[0]), 64'd0);
    advance();
    drive(0, 1'b1, 64'h53, 1'b0, 1'b0); settle();
    chk("t5_occ0", 64'(occ_a[0]), 64'd0);
    chk("t5_ov0", 64'(out_valid_a[0]), 64'd0);
    chk("t5_kept", out_data_a[0], 64'h51);
    chk("t5_ir", 64'(in_ready_a[0]), 64'd1);
    advance();
    drive(0, 1'b0, 64'h00, 1'b1, 1'b0); settle(); chk("t5_early", 64'(out_valid_a[0]), 64'd0); advance();
    settle(); chk("t5_od53", out_data_a[0], 64'h53); advance();
    idle(3);

    // randomized traffic on all configurations
    for (int c = 0; c < 10000; c++) begin
      if (c % 500 == 0) begin
        for (int k = 0; k < NDUT; k++) begin
          rate_in[k]  = $urandom_range(10, 100);
          rate_out[k] = $urandom_range(10, 100);
        end
      end
      reset = (c >= 5000 && c < 5002);
      for (int k = 0; k < NDUT; k++) begin
        flush_a[k] = ($urandom_range(0, 63) == 0);
        if (!pending[k]) begin
          in_valid_a[k] = ($urandom_range(1, 100) <= rate_in[k]);
          in_data_a[k]  = {$urandom, $urandom} & mask_of(k);
        end
        out_ready_a[k] = ($urandom_range(1, 100) <= rate_out[k]);
      end
      settle();
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
